// File: rtl/sensor_frontend.sv
// sensor_frontend: conditions the board-side sensor pins for the smart-home
// controller. Each raw binary sensor is synchronized and debounced. The fire
// alarm asserts without delay but still debounces its release. A bit-strobed
// serial receiver delivers a validated 7-bit temperature word on ST.
//
// Receiver states
//   state  | meaning
//   S_IDLE | line idle, waiting for a strobed start bit (ts_data == 0)
//   S_DATA | shifting in 7 payload bits, MSB first
//   S_STOP | expecting the stop bit; 1 commits ST, 0 discards the frame
module sensor_frontend #(
  parameter int         DEB_CYCLES = 4,
  parameter logic [6:0] TEMP_RST   = 7'd25
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       raw_fd,
  input  logic       raw_rd,
  input  logic       raw_w,
  input  logic       raw_fa,
  input  logic       ts_bit_en,
  input  logic       ts_data,
  output logic       SFD,
  output logic       SRD,
  output logic       SW,
  output logic       SFA,
  output logic [6:0] ST,
  output logic       st_upd,
  output logic       frame_err
);

  localparam int            CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam int            FA       = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } rx_state_t;

  // Bit order in the sensor vectors: 0 front door, 1 rear door, 2 window, 3 fire alarm.
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb;
  logic [CW-1:0] r_cnt [4];

  rx_state_t     r_state;
  rx_state_t     w_state_nxt;
  logic [2:0]    r_bitcnt;
  logic [2:0]    w_bitcnt_nxt;
  logic [6:0]    r_shift;
  logic [6:0]    w_shift_nxt;
  logic          w_load;
  logic          w_err;
  logic [6:0]    r_st;
  logic          r_upd;
  logic          r_err;

  assign w_raw = {raw_fa, raw_w, raw_rd, raw_fd};

  // Two-flop synchronizers for the asynchronous sensor pins.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: an output follows its synchronized input only after DEB_CYCLES
  // consecutive disagreeing cycles; the fire alarm sets immediately instead.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_deb <= '0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i == FA && r_sync2[i]) begin
          r_deb[i] <= 1'b1;
          r_cnt[i] <= '0;
        end else if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Receiver state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
    end
  end

  // Receiver next-state logic; nothing moves unless the bit strobe is high.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_load       = 1'b0;
    w_err        = 1'b0;
    if (ts_bit_en) begin
      case (r_state)
        S_IDLE: begin
          if (!ts_data) begin
            w_state_nxt  = S_DATA;
            w_bitcnt_nxt = '0;
          end
        end
        S_DATA: begin
          w_shift_nxt  = {r_shift[5:0], ts_data};
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd6) begin
            w_state_nxt = S_STOP;
          end
        end
        S_STOP: begin
          // The stop strobe only closes the frame; it never doubles as a start bit.
          w_state_nxt = S_IDLE;
          if (ts_data) begin
            w_load = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Temperature holding register and the registered one-cycle status pulses.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_st  <= TEMP_RST;
      r_upd <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_upd <= w_load;
      r_err <= w_err;
      if (w_load) begin
        r_st <= r_shift;
      end
    end
  end

  assign SFD       = r_deb[0];
  assign SRD       = r_deb[1];
  assign SW        = r_deb[2];
  assign SFA       = r_deb[FA];
  assign ST        = r_st;
  assign st_upd    = r_upd;
  assign frame_err = r_err;

endmodule

// File: doc/sensor_frontend.md
Name: sensor_frontend

Overview:
- Input-side companion to the smart-home controller FSM. Produces the controller's sensor inputs SFD, SRD, SW, SFA and ST[6:0].
- Synchronizes and debounces the four raw binary sensors.
- Receives the 7-bit temperature from the thermometer over a bit-strobed serial link and holds it as a stable, validated ST word.
- Sits between the board pins and the controller; its outputs connect directly to the controller's same-named inputs.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronized cycles required before a debounced output changes (legal 2..15).
- TEMP_RST, 7'd25: value of ST after reset and until the first good frame.

Ports:
- Clk  in  1  single system clock, rising edge.
- Rst  in  1  reset, asynchronous, active-low (0 = reset).
- raw_fd  in  1  front-door sensor pin, asynchronous.
- raw_rd  in  1  rear-door sensor pin, asynchronous.
- raw_w  in  1  window sensor pin, asynchronous.
- raw_fa  in  1  fire-alarm sensor pin, asynchronous.
- ts_bit_en  in  1  one-cycle strobe qualifying ts_data; synchronous to Clk.
- ts_data  in  1  serial temperature bit; idle high; synchronous to Clk.
- SFD  out  1  debounced front door.
- SRD  out  1  debounced rear door.
- SW  out  1  debounced window.
- SFA  out  1  fire alarm, fast-assert / debounced-deassert.
- ST  out  7  last validly received temperature.
- st_upd  out  1  one-cycle pulse: ST just loaded.
- frame_err  out  1  one-cycle pulse: frame discarded.

Behaviour:
- Reset (Rst=0, asynchronous):
  - SFD=SRD=SW=SFA=0, ST=TEMP_RST, st_upd=0, frame_err=0.
  - All synchronizer flops 0, all debounce counters 0, receiver in IDLE.
  - Reset asserted mid-frame abandons the frame; no pulse is issued.
- Synchronizers: each raw_* passes through a 2-flop synchronizer; s_x denotes its output.
- Debounce (SFD, SRD, SW, and SFA deassert):
  - Per-input counter, width ceil(log2(DEB_CYCLES)).
  - Cycle with s_x == out_x: counter cleared.
  - Cycle with s_x != out_x and counter == DEB_CYCLES-1: out_x <= s_x, counter cleared.
  - Otherwise the counter increments.
  - A raw edge at cycle t that stays stable appears on the output at cycle t+2+DEB_CYCLES.
  - Glitches shorter than DEB_CYCLES synchronized cycles are never visible.
- SFA is fail-safe:
  - s_fa==1 sets SFA the next cycle, i.e. 3 cycles after the raw edge, with no debounce.
  - Deassert uses the normal debounce rule.
  - Any s_fa==1 cycle during the deassert count clears the counter.
- Serial receiver FSM, states IDLE, DATA, STOP. All transitions happen only on cycles with ts_bit_en=1; other cycles hold state.
  - IDLE: ts_data==0 (start bit) -> DATA, bitcnt=0. ts_data==1 -> stay.
  - DATA: shift ts_data into a 7-bit register, MSB first, and bitcnt++. After the 7th bit (bitcnt==6) -> STOP.
  - STOP, ts_data==1: ST <= shift register, st_upd=1 for exactly the next cycle, -> IDLE.
  - STOP, ts_data==0: ST unchanged, frame_err=1 for exactly the next cycle, -> IDLE. The stop-bit cycle does not count as a new start bit.
  - Data-bit values never influence framing, so an all-zero or all-one payload is legal.
  - Back-to-back frames are allowed: a start bit may arrive on the strobe immediately after the stop bit.
- ST only changes on a good frame; no partial update is ever visible.
- st_upd and frame_err are mutually exclusive and registered.
- Debounce paths and receiver are independent; simultaneous events on all inputs are processed in parallel with no interaction.

Test Plan:
- Reset values: hold Rst=0 with ts_data toggling and all raw_* high -> SFD=SRD=SW=SFA=0, ST=25, st_upd=frame_err=0. Release Rst -> SFD/SRD/SW rise at cycle 2+4=6 after release, SFA at cycle 3.
- Glitch rejection (DEB_CYCLES=4): raw_fd high 3 cycles then low -> SFD stays 0. raw_fd high 4+ cycles from cycle t -> SFD=1 at t+6. Falling edge -> SFD=0 four debounce cycles later.
- Fire alarm: raw_fa 1-cycle pulse -> SFA=1 at t+3. SFA returns to 0 at t+3+DEB_CYCLES. A second pulse during the deassert count restarts the count.
- Good frame: strobes carrying start 0, data 1010101 (0x55), stop 1 -> ST=0x55, st_upd pulses once in the cycle after the stop strobe. Idle gaps of 0-5 cycles between strobes do not change the result.
- Frame error: payload 0x7F with stop bit 0 -> ST keeps its prior value, frame_err pulses once. An immediately following good frame of 0x12 -> ST=0x12.
- Reset mid-frame: assert Rst after 3 data bits, release, then send frame 0x40 -> no pulse during reset, ST=25 until the 0x40 frame lands, then ST=0x40.
